// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Sequencing FSM for a multicycle MIPS datapath. It decodes opcode/funct
//   and steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
//   It stalls on ihit/dhit and halts on a wait timeout or an illegal opcode.
//
// Optional feature macro: MCU_LLSC_EN
//   Defined:   LL/SC decode as atomic load / store-conditional.
//   Undefined: LL/SC are illegal and datomic is tied to 0.
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   instructionOp, funct     opcode / funct fields from the IR
//   ihit, dhit               instruction / data access complete
//   zero                     ALU zero flag, used by branches in EXEC
//   iread, dread, dwrite     memory request strobes (combinational, reset-gated)
//   irEn, pcEn, regWrite     IR load, PC update, RF write (combinational, reset-gated)
//   aluCtrl, aluSrc, regDst, extension, wbSel   select fields latched in DECODE
//   pcSel                    0 = PC+4, 1 = branch, 2 = jump, 3 = jr
//   datomic                  atomic data access during MEM (LL/SC)
//   halt, timeout_err, illegal_err              sticky halt and its cause
//   state                    current FSM state, for debug

package cpu_types_pkg;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNC_W  = 6;
  localparam int unsigned ALUOP_W = 4;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef enum logic [3:0] {
    CLS_ALU     = 4'd0,
    CLS_LOAD    = 4'd1,
    CLS_STORE   = 4'd2,
    CLS_BR      = 4'd3,
    CLS_J       = 4'd4,
    CLS_JAL     = 4'd5,
    CLS_JR      = 4'd6,
    CLS_HALT    = 4'd7,
    CLS_ILLEGAL = 4'd8,
    CLS_SC      = 4'd9
  } cls_t;

  // Decoded control captured in DECODE and held for the rest of the instruction
  typedef struct packed {
    cls_t       cls;
    logic       br_eq;
    aluop_t     alu;
    logic [1:0] alu_src;
    logic [1:0] reg_dst;
    logic [1:0] ext;
    logic [2:0] wb_sel;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_LL    = 6'h30;
  localparam logic [5:0] OP_SC    = 6'h38;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;
endpackage

module multicycle_control_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned OP_W         = cpu_types_pkg::OP_W,
  parameter int unsigned FUNC_W       = cpu_types_pkg::FUNC_W,
  parameter int unsigned WAIT_TIMEOUT = 64,
  parameter int unsigned TO_CNT_W     = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [OP_W-1:0]   instructionOp,
  input  logic [FUNC_W-1:0] funct,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              zero,
  output logic              iread,
  output logic              dread,
  output logic              dwrite,
  output logic              irEn,
  output logic              pcEn,
  output logic              regWrite,
  output aluop_t            aluCtrl,
  output logic [1:0]        aluSrc,
  output logic [1:0]        regDst,
  output logic [1:0]        extension,
  output logic [2:0]        wbSel,
  output logic [1:0]        pcSel,
  output logic              datomic,
  output logic              halt,
  output logic              timeout_err,
  output logic              illegal_err,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALTED = 3'd5
  } state_t;

  localparam int unsigned TO_LAST = (WAIT_TIMEOUT == 0) ? 0 : WAIT_TIMEOUT - 1;

  localparam logic [1:0] PC_SEL_SEQ = 2'd0;
  localparam logic [1:0] PC_SEL_BR  = 2'd1;
  localparam logic [1:0] PC_SEL_JMP = 2'd2;
  localparam logic [1:0] PC_SEL_JR  = 2'd3;

  localparam ctrl_t CTRL_RST = '{cls: CLS_ALU, br_eq: 1'b0, alu: ALU_SLL,
                                 alu_src: 2'd0, reg_dst: 2'd0, ext: 2'd0,
                                 wb_sel: 3'd0};

  state_t                state_q, state_d;
  logic [TO_CNT_W-1:0]   to_cnt_q, to_cnt_d;
  ctrl_t                 ctrl_q, dec;
  logic                  halt_q, timeout_err_q, illegal_err_q;
  logic                  iread_c, dread_c, dwrite_c, ir_en_c, pc_en_c, reg_write_c;
  logic [1:0]            pc_sel_c;
  logic                  set_timeout, set_illegal, to_expire;
  logic [5:0]            op, fn;

  assign op = 6'(instructionOp);
  assign fn = 6'(funct);

  // Opcode/funct decode into datapath selects and instruction class
  always_comb begin
    dec.cls     = CLS_ILLEGAL;
    dec.br_eq   = 1'b0;
    dec.alu     = ALU_SLL;
    dec.alu_src = 2'd0;
    dec.reg_dst = 2'd0;
    dec.ext     = 2'd0;
    dec.wb_sel  = 3'd0;
    case (op)
      OP_RTYPE: begin
        dec.cls     = CLS_ALU;
        dec.reg_dst = 2'd1;
        case (fn)
          F_SLL:          begin dec.alu = ALU_SLL; dec.alu_src = 2'd2; end
          F_SRL:          begin dec.alu = ALU_SRL; dec.alu_src = 2'd2; end
          F_JR:           dec.cls = CLS_JR;
          F_ADD, F_ADDU:  dec.alu = ALU_ADD;
          F_SUB, F_SUBU:  dec.alu = ALU_SUB;
          F_AND:          dec.alu = ALU_AND;
          F_OR:           dec.alu = ALU_OR;
          F_XOR:          dec.alu = ALU_XOR;
          F_NOR:          dec.alu = ALU_NOR;
          F_SLT:          dec.alu = ALU_SLT;
          F_SLTU:         dec.alu = ALU_SLTU;
          default:        dec.cls = CLS_ILLEGAL;
        endcase
      end
      OP_J:   dec.cls = CLS_J;
      OP_JAL: begin dec.cls = CLS_JAL; dec.reg_dst = 2'd2; dec.wb_sel = 3'd2; end
      OP_BEQ, OP_BNE: begin
        dec.cls   = CLS_BR;
        dec.br_eq = (op == OP_BEQ);
        dec.alu   = ALU_SUB;
        dec.ext   = 2'd1;
      end
      OP_ADDI, OP_ADDIU: begin
        dec.cls = CLS_ALU; dec.alu = ALU_ADD; dec.alu_src = 2'd1; dec.ext = 2'd1;
      end
      OP_SLTI: begin
        dec.cls = CLS_ALU; dec.alu = ALU_SLT; dec.alu_src = 2'd1; dec.ext = 2'd1;
      end
      OP_SLTIU: begin
        dec.cls = CLS_ALU; dec.alu = ALU_SLTU; dec.alu_src = 2'd1; dec.ext = 2'd1;
      end
      OP_ANDI: begin dec.cls = CLS_ALU; dec.alu = ALU_AND; dec.alu_src = 2'd1; end
      OP_ORI:  begin dec.cls = CLS_ALU; dec.alu = ALU_OR;  dec.alu_src = 2'd1; end
      OP_XORI: begin dec.cls = CLS_ALU; dec.alu = ALU_XOR; dec.alu_src = 2'd1; end
      // LUI bypasses the ALU: the upper-extended immediate is written back directly
      OP_LUI: begin
        dec.cls = CLS_ALU; dec.alu_src = 2'd1; dec.ext = 2'd2; dec.wb_sel = 3'd3;
      end
      OP_LW: begin
        dec.cls = CLS_LOAD; dec.alu = ALU_ADD; dec.alu_src = 2'd1; dec.ext = 2'd1;
        dec.wb_sel = 3'd1;
      end
      OP_SW: begin
        dec.cls = CLS_STORE; dec.alu = ALU_ADD; dec.alu_src = 2'd1; dec.ext = 2'd1;
      end
`ifdef MCU_LLSC_EN
      OP_LL: begin
        dec.cls = CLS_LOAD; dec.alu = ALU_ADD; dec.alu_src = 2'd1; dec.ext = 2'd1;
        dec.wb_sel = 3'd1;
      end
      // SC writes memory in MEM and then writes its success flag back in WB
      OP_SC: begin
        dec.cls = CLS_SC; dec.alu = ALU_ADD; dec.alu_src = 2'd1; dec.ext = 2'd1;
        dec.wb_sel = 3'd4;
      end
`endif
      OP_HALT: dec.cls = CLS_HALT;
      default: dec.cls = CLS_ILLEGAL;
    endcase
  end

  assign to_expire = (WAIT_TIMEOUT != 0) && (to_cnt_q == TO_CNT_W'(TO_LAST));

  // Next-state and strobe decode; the wait counter only survives in FETCH/MEM stalls
  always_comb begin
    state_d     = state_q;
    to_cnt_d    = '0;
    iread_c     = 1'b0;
    dread_c     = 1'b0;
    dwrite_c    = 1'b0;
    ir_en_c     = 1'b0;
    pc_en_c     = 1'b0;
    reg_write_c = 1'b0;
    pc_sel_c    = PC_SEL_SEQ;
    set_timeout = 1'b0;
    set_illegal = 1'b0;
    case (state_q)
      ST_FETCH: begin
        iread_c = 1'b1;
        if (ihit) begin
          ir_en_c = 1'b1;
          state_d = ST_DECODE;
        end else if (to_expire) begin
          state_d     = ST_HALTED;
          set_timeout = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_CNT_W'(1);
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        case (ctrl_q.cls)
          CLS_BR: begin
            pc_en_c  = 1'b1;
            pc_sel_c = (zero ~^ ctrl_q.br_eq) ? PC_SEL_BR : PC_SEL_SEQ;
            state_d  = ST_FETCH;
          end
          CLS_J:  begin pc_en_c = 1'b1; pc_sel_c = PC_SEL_JMP; state_d = ST_FETCH; end
          CLS_JR: begin pc_en_c = 1'b1; pc_sel_c = PC_SEL_JR;  state_d = ST_FETCH; end
          CLS_ALU, CLS_JAL:            state_d = ST_WB;
          CLS_LOAD, CLS_STORE, CLS_SC: state_d = ST_MEM;
          CLS_HALT:                    state_d = ST_HALTED;
          default: begin
            state_d     = ST_HALTED;
            set_illegal = 1'b1;
          end
        endcase
      end
      ST_MEM: begin
        dread_c  = (ctrl_q.cls == CLS_LOAD);
        dwrite_c = (ctrl_q.cls == CLS_STORE) || (ctrl_q.cls == CLS_SC);
        if (dhit) begin
          if (ctrl_q.cls == CLS_STORE) begin
            pc_en_c = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (to_expire) begin
          state_d     = ST_HALTED;
          set_timeout = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_CNT_W'(1);
        end
      end
      ST_WB: begin
        reg_write_c = 1'b1;
        pc_en_c     = 1'b1;
        pc_sel_c    = (ctrl_q.cls == CLS_JAL) ? PC_SEL_JMP : PC_SEL_SEQ;
        state_d     = ST_FETCH;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_FETCH;
    endcase
  end

  // State, wait counter, decoded control and sticky flags
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_FETCH;
      to_cnt_q      <= '0;
      ctrl_q        <= CTRL_RST;
      halt_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      illegal_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      to_cnt_q      <= to_cnt_d;
      if (state_q == ST_DECODE) ctrl_q <= dec;
      halt_q        <= (state_d == ST_HALTED);
      timeout_err_q <= timeout_err_q | set_timeout;
      illegal_err_q <= illegal_err_q | set_illegal;
    end
  end

`ifdef MCU_LLSC_EN
  logic atomic_q;

  // LL/SC flag captured alongside the other decoded fields
  always_ff @(posedge CLK) begin
    if (RST) begin
      atomic_q <= 1'b0;
    end else if (state_q == ST_DECODE) begin
      atomic_q <= (op == OP_LL) || (op == OP_SC);
    end
  end

  assign datomic = ~RST & (state_q == ST_MEM) & atomic_q;
`else
  assign datomic = 1'b0;
`endif

  // Strobes are forced low during reset so nothing leaks before the state settles
  assign iread       = iread_c     & ~RST;
  assign dread       = dread_c     & ~RST;
  assign dwrite      = dwrite_c    & ~RST;
  assign irEn        = ir_en_c     & ~RST;
  assign pcEn        = pc_en_c     & ~RST;
  assign regWrite    = reg_write_c & ~RST;
  assign pcSel       = RST ? PC_SEL_SEQ : pc_sel_c;

  assign aluCtrl     = ctrl_q.alu;
  assign aluSrc      = ctrl_q.alu_src;
  assign regDst      = ctrl_q.reg_dst;
  assign extension   = ctrl_q.ext;
  assign wbSel       = ctrl_q.wb_sel;
  assign halt        = halt_q;
  assign timeout_err = timeout_err_q;
  assign illegal_err = illegal_err_q;
  assign state       = state_q;

endmodule
